// File: rtl/mips_run_checker.sv
// Run monitor and result checker for the single-cycle MIPS core.
// It waits for the program to idle on NOPs or for the watchdog to expire.
// It then sweeps a window of data memory against a reference port and
// keeps a saturating pass count for each category.

// Per-category saturating pass counter, cleared when a new run starts.
module mips_run_checker_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);
  // Count matches and hold at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     cnt <= '0;
    else if (clr)                cnt <= '0;
    else if (inc && cnt != '1)   cnt <= cnt + 1'b1;
  end
endmodule

module mips_run_checker #(
  parameter int DATA_W    = 32,
  parameter int NUM_WORDS = 22,
  parameter int NUM_CAT   = 6,
  parameter int CAT_W     = 3,
  parameter int TIMEOUT   = 9,
  parameter int WATCHDOG  = 500,
  parameter int CNT_W     = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [DATA_W-1:0]            inst,
  output logic [31:0]                  mem_addr,
  output logic                         mem_rd,
  input  logic [DATA_W-1:0]            mem_rdata,
  output logic [$clog2(NUM_WORDS)-1:0] ref_idx,
  input  logic [DATA_W-1:0]            ref_rdata,
  input  logic [NUM_WORDS*CAT_W-1:0]   cat_map,
  output logic [NUM_CAT*CNT_W-1:0]     pass_cnt,
  output logic                         busy,
  output logic                         done,
  output logic                         wd_fired
);
  localparam int IDX_W = $clog2(NUM_WORDS);
  localparam int NOP_W = $clog2(TIMEOUT + 1);
  localparam int WD_W  = $clog2(WATCHDOG + 1);
  localparam logic [NOP_W-1:0] TO_V   = NOP_W'(TIMEOUT);
  localparam logic [WD_W-1:0]  WD_V   = WD_W'(WATCHDOG);
  localparam logic [IDX_W-1:0] LAST   = IDX_W'(NUM_WORDS - 1);
  localparam logic [CAT_W-1:0] NCAT_V = CAT_W'(NUM_CAT);
  localparam logic [31:0]      BASE_V = 32'(BASE_ADDR);

  typedef enum logic [2:0] {IDLE, RUN, SWEEP, DRAIN, DONE} state_t;

  state_t           state;
  logic [NOP_W-1:0] nop_cnt, nop_nx;
  logic [WD_W-1:0]  watch_cnt, watch_nx;
  logic             to_hit, wd_hit, clr;
  logic             cmp_vld;
  logic [IDX_W-1:0] cmp_idx;
  logic [CAT_W-1:0] cmp_cat;
  logic             hit;

  // Updated RUN counters and the two exit conditions.
  always_comb begin
    nop_nx   = (inst == '0) ? nop_cnt + 1'b1 : '0;
    watch_nx = watch_cnt + 1'b1;
    to_hit   = (nop_nx == TO_V);
    wd_hit   = (watch_nx == WD_V);
  end

  // Results are cleared on the cycle a run is accepted.
  assign clr = start && (state == IDLE || state == DONE);

  // Run/sweep controller; every output is a register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      nop_cnt   <= '0;
      watch_cnt <= '0;
      wd_fired  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_rd    <= 1'b0;
      mem_addr  <= '0;
      ref_idx   <= '0;
    end else begin
      case (state)
        IDLE, DONE: if (start) begin
          state     <= RUN;
          busy      <= 1'b1;
          done      <= 1'b0;
          nop_cnt   <= '0;
          watch_cnt <= '0;
          wd_fired  <= 1'b0;
        end
        RUN: begin
          nop_cnt   <= nop_nx;
          watch_cnt <= watch_nx;
          if (to_hit || wd_hit) begin
            state    <= SWEEP;
            wd_fired <= !to_hit;  // NOP timeout wins a tie
            mem_rd   <= 1'b1;
            mem_addr <= BASE_V;
            ref_idx  <= '0;
          end
        end
        SWEEP: begin
          if (ref_idx == LAST) begin
            state    <= DRAIN;
            mem_rd   <= 1'b0;
            mem_addr <= '0;
            ref_idx  <= '0;
          end else begin
            ref_idx  <= ref_idx + 1'b1;
            mem_addr <= mem_addr + 32'd4;
          end
        end
        DRAIN: begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Compare stage: tracks the index whose data memory answers this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmp_vld <= 1'b0;
      cmp_idx <= '0;
    end else begin
      cmp_vld <= mem_rd;
      cmp_idx <= ref_idx;
    end
  end

  assign cmp_cat = cat_map[cmp_idx*CAT_W +: CAT_W];
  assign hit     = cmp_vld && (mem_rdata == ref_rdata) && (cmp_cat < NCAT_V);

  for (genvar c = 0; c < NUM_CAT; c++) begin : g_cat
    localparam logic [CAT_W-1:0] CODE = CAT_W'(c);
    mips_run_checker_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk (clk),
      .rst (rst),
      .clr (clr),
      .inc (hit && cmp_cat == CODE),
      .cnt (pass_cnt[c*CNT_W +: CNT_W])
    );
  end
endmodule

// File: tb/tb_mips_run_checker.sv
// Scoreboard bench: instance 0 uses default parameters, instance 1 a small
// window with 2-bit counters and a short watchdog.
module tb_mips_run_checker;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // instance 0 (defaults)
  logic        start0 = 1'b0;
  logic [31:0] inst0 = '0, mem_addr0, mem_rdata0 = '0, ref_rdata0 = '0;
  logic        mem_rd0, busy0, done0, wd0;
  logic [4:0]  ref_idx0;
  logic [65:0] cat_map0;
  logic [47:0] pass_cnt0;

  // instance 1 (NUM_WORDS=8, CNT_W=2, WATCHDOG=12)
  logic        start1 = 1'b0;
  logic [31:0] inst1 = '0, mem_addr1, mem_rdata1 = '0, ref_rdata1 = '0;
  logic        mem_rd1, busy1, done1, wd1;
  logic [2:0]  ref_idx1;
  logic [23:0] cat_map1 = '0;
  logic [11:0] pass_cnt1;

  mips_run_checker dut0 (
    .clk(clk), .rst(rst), .start(start0), .inst(inst0), .mem_addr(mem_addr0),
    .mem_rd(mem_rd0), .mem_rdata(mem_rdata0), .ref_idx(ref_idx0),
    .ref_rdata(ref_rdata0), .cat_map(cat_map0), .pass_cnt(pass_cnt0),
    .busy(busy0), .done(done0), .wd_fired(wd0));

  mips_run_checker #(.NUM_WORDS(8), .CNT_W(2), .WATCHDOG(12)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .inst(inst1), .mem_addr(mem_addr1),
    .mem_rd(mem_rd1), .mem_rdata(mem_rdata1), .ref_idx(ref_idx1),
    .ref_rdata(ref_rdata1), .cat_map(cat_map1), .pass_cnt(pass_cnt1),
    .busy(busy1), .done(done1), .wd_fired(wd1));

  // synchronous memory and reference models
  logic [31:0] mem0 [32], ref0 [32], mem1 [8], ref1 [8];
  always @(posedge clk) begin
    if (mem_rd0) mem_rdata0 <= mem0[mem_addr0[6:2]];
    ref_rdata0 <= ref0[ref_idx0];
    if (mem_rd1) mem_rdata1 <= mem1[mem_addr1[4:2]];
    ref_rdata1 <= ref1[ref_idx1];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [47:0] cnt;
    logic        wd;
    int          sw;
    int          dn;
  } exp_t;
  exp_t q0[$], q1[$];

  int checks = 0, errors = 0;
  int t0[2], sweep_seen[2];
  logic dn_q[2], rd_q[2];
  logic dn[2], rd[2], wdv[2];
  logic [47:0] pc[2];
  assign dn[0] = done0;  assign dn[1] = done1;
  assign rd[0] = mem_rd0; assign rd[1] = mem_rd1;
  assign wdv[0] = wd0;   assign wdv[1] = wd1;
  assign pc[0] = pass_cnt0; assign pc[1] = {36'd0, pass_cnt1};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] dcat(input int i);
    if (i == 3 || i == 4 || i == 6) return 3'd0;
    if (i >= 7 && i <= 10)  return 3'd1;
    if (i >= 11 && i <= 14) return 3'd4;
    if (i >= 15 && i <= 18) return 3'd2;
    if (i == 19 || i == 20) return 3'd3;
    if (i == 21) return 3'd5;
    return 3'd7;
  endfunction

  function automatic logic [47:0] pk(input int a0, a1, a2, a3, a4, a5);
    return {a5[7:0], a4[7:0], a3[7:0], a2[7:0], a1[7:0], a0[7:0]};
  endfunction

  // monitor: record sweep start, score each completed run
  task automatic score(input int u);
    exp_t e;
    if ((u == 0 && q0.size() == 0) || (u == 1 && q1.size() == 0)) begin
      checks++; errors++;
      $display("FAIL unexpected_done u%0d act=1 exp=0", u);
    end else begin
      e = (u == 0) ? q0.pop_front() : q1.pop_front();
      chk($sformatf("pass_cnt_u%0d", u), 64'(pc[u]), 64'(e.cnt));
      chk($sformatf("wd_fired_u%0d", u), 64'(wdv[u]), 64'(e.wd));
      chk($sformatf("sweep_cycle_u%0d", u), 64'(sweep_seen[u]), 64'(e.sw));
      chk($sformatf("done_cycle_u%0d", u), 64'(cyc - t0[u]), 64'(e.dn));
    end
  endtask

  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (rd[u] && !rd_q[u]) sweep_seen[u] = cyc - t0[u];
      if (dn[u] && !dn_q[u]) score(u);
      rd_q[u] = rd[u];
      dn_q[u] = dn[u];
    end
  end

  task automatic expect_run(input int u, input logic [47:0] cnt, input logic wd,
                            input int sw, input int dnc);
    exp_t e;
    e.cnt = cnt; e.wd = wd; e.sw = sw; e.dn = dnc;
    if (u == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  task automatic set_sig(input int u, input logic s, input logic [31:0] i);
    if (u == 0) begin start0 = s; inst0 = i; end
    else        begin start1 = s; inst1 = i; end
  endtask

  // start pulse, then nz nonzero instructions, then NOPs held
  task automatic run_u(input int u, input int nz, input bit poke);
    @(negedge clk);
    set_sig(u, 1'b1, 32'h0);
    t0[u] = cyc + 1;
    @(negedge clk);
    for (int k = 0; k < nz; k++) begin
      set_sig(u, poke && k == 2, 32'h2108_0001 + k);
      @(negedge clk);
    end
    set_sig(u, 1'b0, 32'h0);
  endtask

  task automatic wait_done(input int u, input int lim);
    int n = 0;
    while (!dn[u] && n < lim) begin
      @(negedge clk);
      n++;
    end
    if (!dn[u]) begin
      checks++; errors++;
      $display("FAIL done_timeout u%0d act=0 exp=1", u);
    end
  endtask

  task automatic chk_zero0(input string tag);
    chk({tag, "_busy"},     64'(busy0),     64'd0);
    chk({tag, "_done"},     64'(done0),     64'd0);
    chk({tag, "_wd"},       64'(wd0),       64'd0);
    chk({tag, "_mem_rd"},   64'(mem_rd0),   64'd0);
    chk({tag, "_mem_addr"}, 64'(mem_addr0), 64'd0);
    chk({tag, "_ref_idx"},  64'(ref_idx0),  64'd0);
    chk({tag, "_pass_cnt"}, 64'(pass_cnt0), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    for (int i = 0; i < 32; i++) begin
      ref0[i] = 32'h1000_0000 + i * 32'h111;
      mem0[i] = ref0[i];
    end
    mem0[8] = ~ref0[8];
    for (int i = 0; i < 22; i++) cat_map0[i*3 +: 3] = dcat(i);
    for (int i = 0; i < 8; i++) begin
      ref1[i] = 32'hA5A5_0000 + i;
      mem1[i] = ref1[i];
    end
    for (int u = 0; u < 2; u++) begin
      t0[u] = 0; sweep_seen[u] = -1; dn_q[u] = 1'b0; rd_q[u] = 1'b0;
    end

    #12;
    chk_zero0("reset");
    @(negedge clk);
    rst = 1'b0;

    // NOP exit after 5 real instructions; start pulse during RUN is ignored
    expect_run(0, pk(3, 3, 4, 2, 4, 1), 1'b0, 14, 37);
    run_u(0, 5, 1'b1);
    wait_done(0, 100);

    // watchdog-only exit, restarted from DONE, word 21 now wrong
    mem0[8] = ref0[8];
    mem0[21] = ref0[21] ^ 32'h0000_0100;
    expect_run(0, pk(3, 4, 4, 2, 4, 0), 1'b1, 500, 523);
    run_u(0, 520, 1'b0);
    wait_done(0, 100);

    // both limits on cycle 500: NOP timeout wins
    expect_run(0, pk(3, 4, 4, 2, 4, 0), 1'b0, 500, 523);
    run_u(0, 491, 1'b0);
    wait_done(0, 100);

    // small instance: coincident limits on cycle 12, counter saturates at 3
    expect_run(1, 48'h3, 1'b0, 12, 21);
    run_u(1, 3, 1'b0);
    wait_done(1, 100);

    // small instance: watchdog-only, only words 6,7 match
    for (int i = 0; i < 6; i++) mem1[i] = ~ref1[i];
    expect_run(1, 48'h2, 1'b1, 12, 21);
    run_u(1, 20, 1'b0);
    wait_done(1, 100);

    // reset in mid-sweep at i = 10, then a clean full run
    run_u(0, 0, 1'b0);
    for (int n = 0; n < 100 && !(mem_rd0 && ref_idx0 == 5'd10); n++) @(negedge clk);
    chk("reach_idx10", 64'(mem_rd0 && ref_idx0 == 5'd10), 64'd1);
    rst = 1'b1;
    #1;
    chk_zero0("midrst");
    @(negedge clk);
    rst = 1'b0;
    expect_run(0, pk(3, 4, 4, 2, 4, 0), 1'b0, 9, 32);
    run_u(0, 0, 1'b0);
    wait_done(0, 100);

    repeat (3) @(negedge clk);
    chk("queue0_empty", 64'(q0.size()), 64'd0);
    chk("queue1_empty", 64'(q1.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
